// File: rtl/acc_pkg.sv
// Shared definitions for the bit-serial accumulator: operation encodings
// and sizing helpers used by the top level and the serial ALU.
package acc_pkg;

  // Beat operation, sampled once at digit 0.
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LDN = 2'b01,
    OP_SUB = 2'b10,
    OP_ADD = 2'b11
  } op_t;

  // Width of the digit counter covering data digits plus flyback digits.
  function automatic int digit_width(input int word_bits, input int flyback_time);
    return $clog2(word_bits + flyback_time);
  endfunction

  // Carry seed at beat start: subtraction-style ops add the +1 of the two's complement.
  function automatic logic carry_init(input op_t op);
    logic c;
    case (op)
      OP_SUB:  c = 1'b1;
      OP_LDN:  c = 1'b1;
      OP_ADD:  c = 1'b0;
      OP_NOP:  c = 1'b0;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/acc_serial_alu.sv
// One-digit serial full adder with operand select/inversion and the carry
// register that links successive digits of a beat.
module acc_serial_alu
  import acc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic beat_start,
  input  logic data_digit,
  input  op_t  op,
  input  logic a_bit,
  input  logic s_bit,
  output logic sum,
  output logic carry_in,
  output logic carry_out
);

  logic carry_r;
  logic a_sel_s;
  logic s_sel_s;
  logic [1:0] total_s;

  // Digit 0 starts from the op's carry seed; later digits use the stored carry.
  always_comb begin
    if (beat_start) begin
      carry_in = carry_init(op);
    end else begin
      carry_in = carry_r;
    end
  end

  // LDN ignores the accumulator; only ADD uses the operand uninverted.
  always_comb begin
    a_sel_s = a_bit;
    s_sel_s = ~s_bit;
    case (op)
      OP_LDN: begin
        a_sel_s = 1'b0;
        s_sel_s = ~s_bit;
      end
      OP_SUB: begin
        a_sel_s = a_bit;
        s_sel_s = ~s_bit;
      end
      OP_ADD: begin
        a_sel_s = a_bit;
        s_sel_s = s_bit;
      end
      default: begin
        a_sel_s = a_bit;
        s_sel_s = ~s_bit;
      end
    endcase
  end

  // Full add of the selected operands and incoming carry.
  always_comb begin
    total_s   = {1'b0, a_sel_s} + {1'b0, s_sel_s} + {1'b0, carry_in};
    sum       = total_s[0];
    carry_out = total_s[1];
  end

  // Carry advances only on data digits; flyback leaves it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r <= 1'b0;
    end else if (data_digit) begin
      carry_r <= carry_out;
    end else begin
      carry_r <= carry_r;
    end
  end

endmodule

// File: rtl/serial_accumulator.sv
// Bit-serial accumulator: one word combined LSB-first with a serial store
// operand once per beat; the result is committed atomically at the end of
// the data digits so the visible accumulator never holds a partial word.
module serial_accumulator
  import acc_pkg::*;
#(
  parameter int WORD_BITS    = 32,
  parameter int FLYBACK_TIME = 4,
  localparam int DIGIT_W     = digit_width(WORD_BITS, FLYBACK_TIME)
) (
  input  logic                 w_CLK,
  input  logic                 w_RST_N,
  input  logic                 w_S_DATA_IN,
  input  logic [1:0]           b_OP,
  input  logic                 w_OP_VALID,
  output logic                 w_A_DATA_OUT,
  output logic [WORD_BITS-1:0] b_A_PAR,
  output logic                 w_A_NEG,
  output logic                 w_A_IS_ZERO,
  output logic                 w_OVF,
  output logic [DIGIT_W-1:0]   b_DIGIT,
  output logic                 w_BEAT_START,
  output logic                 w_COMMIT
);

  localparam logic [DIGIT_W-1:0] LAST_DATA  = DIGIT_W'(WORD_BITS - 1);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(WORD_BITS + FLYBACK_TIME - 1);

  logic [DIGIT_W-1:0]   digit_r;
  op_t                  op_r;
  logic [WORD_BITS-2:0] shadow_r;
  logic [WORD_BITS-1:0] acc_r;
  logic                 ovf_r;
  logic                 commit_r;

  logic beat_start_s;
  logic data_digit_s;
  logic last_data_s;
  op_t  op_in_s;
  op_t  cur_op_s;
  logic acc_bit_s;
  logic sum_s;
  logic carry_in_s;
  logic carry_out_s;
  logic write_s;
  logic commit_s;

  // Beat phase decode and the op in force for the current digit.
  always_comb begin
    beat_start_s = (digit_r == {DIGIT_W{1'b0}});
    data_digit_s = (digit_r <= LAST_DATA);
    last_data_s  = (digit_r == LAST_DATA);
    if (w_OP_VALID) begin
      op_in_s = op_t'(b_OP);
    end else begin
      op_in_s = OP_NOP;
    end
    if (beat_start_s) begin
      cur_op_s = op_in_s;
    end else begin
      cur_op_s = op_r;
    end
    write_s  = data_digit_s && (cur_op_s != OP_NOP);
    commit_s = last_data_s && (cur_op_s != OP_NOP);
  end

  // Committed accumulator bit at the current digit; zero during flyback.
  always_comb begin
    acc_bit_s = 1'b0;
    for (int i = 0; i < WORD_BITS; i++) begin
      if (digit_r == DIGIT_W'(i)) begin
        acc_bit_s = acc_r[i];
      end else begin
        acc_bit_s = acc_bit_s;
      end
    end
  end

  acc_serial_alu u_alu (
    .clk        (w_CLK),
    .rst_n      (w_RST_N),
    .beat_start (beat_start_s),
    .data_digit (data_digit_s),
    .op         (cur_op_s),
    .a_bit      (acc_bit_s),
    .s_bit      (w_S_DATA_IN),
    .sum        (sum_s),
    .carry_in   (carry_in_s),
    .carry_out  (carry_out_s)
  );

  // Free-running digit counter wrapping at the end of flyback.
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      digit_r <= {DIGIT_W{1'b0}};
    end else if (digit_r == LAST_DIGIT) begin
      digit_r <= {DIGIT_W{1'b0}};
    end else begin
      digit_r <= digit_r + DIGIT_W'(1);
    end
  end

  // Latch the beat's op at digit 0 so later b_OP changes are ignored.
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      op_r <= OP_NOP;
    end else if (beat_start_s) begin
      op_r <= op_in_s;
    end else begin
      op_r <= op_r;
    end
  end

  // Collect sum bits of the lower digits; the MSB goes straight into the commit.
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      shadow_r <= {(WORD_BITS-1){1'b0}};
    end else begin
      for (int i = 0; i < WORD_BITS - 1; i++) begin
        if (write_s && (digit_r == DIGIT_W'(i))) begin
          shadow_r[i] <= sum_s;
        end
      end
    end
  end

  // Atomic commit of the full word and its overflow at the last data digit.
  always_ff @(posedge w_CLK or negedge w_RST_N) begin
    if (!w_RST_N) begin
      acc_r    <= {WORD_BITS{1'b0}};
      ovf_r    <= 1'b0;
      commit_r <= 1'b0;
    end else if (commit_s) begin
      acc_r    <= {sum_s, shadow_r};
      ovf_r    <= carry_in_s ^ carry_out_s;
      commit_r <= 1'b1;
    end else begin
      acc_r    <= acc_r;
      ovf_r    <= ovf_r;
      commit_r <= 1'b0;
    end
  end

  assign w_A_DATA_OUT = acc_bit_s;
  assign b_A_PAR      = acc_r;
  assign w_A_NEG      = acc_r[WORD_BITS-1];
  assign w_A_IS_ZERO  = (acc_r == {WORD_BITS{1'b0}});
  assign w_OVF        = ovf_r;
  assign b_DIGIT      = digit_r;
  assign w_BEAT_START = beat_start_s;
  assign w_COMMIT     = commit_r;

endmodule

// File: tb/tb_serial_accumulator.sv
// Self-checking bench: random and directed beats against an integer
// arithmetic model of the accumulator, plus a 32-bit/1-flyback instance.
module tb_serial_accumulator;

  localparam int WB   = 8;
  localparam int FB   = 4;
  localparam int BEAT = WB + FB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance signals
  logic       rst_n;
  logic       s_in;
  logic [1:0] op;
  logic       op_valid;
  logic       data_out;
  logic [7:0] par;
  logic       neg;
  logic       is_zero;
  logic       ovf;
  logic [3:0] digit;
  logic       beat_start;
  logic       commit;

  // 32-bit instance signals
  logic        rst32_n;
  logic        s32;
  logic [1:0]  op32;
  logic        valid32;
  logic        data_out32;
  logic [31:0] par32;
  logic        neg32;
  logic        zero32;
  logic        ovf32;
  logic [5:0]  digit32;
  logic        beat_start32;
  logic        commit32;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] a_m;
  logic       ovf_m;

  serial_accumulator #(.WORD_BITS(WB), .FLYBACK_TIME(FB)) dut (
    .w_CLK(clk), .w_RST_N(rst_n), .w_S_DATA_IN(s_in), .b_OP(op),
    .w_OP_VALID(op_valid), .w_A_DATA_OUT(data_out), .b_A_PAR(par),
    .w_A_NEG(neg), .w_A_IS_ZERO(is_zero), .w_OVF(ovf), .b_DIGIT(digit),
    .w_BEAT_START(beat_start), .w_COMMIT(commit)
  );

  serial_accumulator #(.WORD_BITS(32), .FLYBACK_TIME(1)) dut32 (
    .w_CLK(clk), .w_RST_N(rst32_n), .w_S_DATA_IN(s32), .b_OP(op32),
    .w_OP_VALID(valid32), .w_A_DATA_OUT(data_out32), .b_A_PAR(par32),
    .w_A_NEG(neg32), .w_A_IS_ZERO(zero32), .w_OVF(ovf32), .b_DIGIT(digit32),
    .w_BEAT_START(beat_start32), .w_COMMIT(commit32)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Signed-integer reference of one committed operation.
  task automatic model_op(input logic [1:0] o, input logic [7:0] s);
    int sa;
    int ss;
    int ex;
    sa = $signed(a_m);
    ss = $signed(s);
    case (o)
      2'd1:    ex = -ss;
      2'd2:    ex = sa - ss;
      2'd3:    ex = sa + ss;
      default: ex = sa;
    endcase
    a_m   = ex[7:0];
    ovf_m = (ex > 127) || (ex < -128);
  endtask

  // Runs one full beat starting at the negedge where digit 0 is showing.
  task automatic run_beat(input logic [1:0] o, input logic v, input logic [7:0] s);
    logic [7:0] a_old;
    logic       ovf_old;
    logic       does_commit;
    logic [7:0] cur;
    logic       cur_ovf;
    a_old       = a_m;
    ovf_old     = ovf_m;
    does_commit = v && (o != 2'd0);
    if (does_commit) model_op(o, s);
    for (int d = 0; d < BEAT; d++) begin
      cur     = (d < WB) ? a_old : a_m;
      cur_ovf = (d < WB) ? ovf_old : ovf_m;
      check_val("digit", digit, d);
      check_val("beat_start", beat_start, d == 0);
      check_val("par", par, cur);
      check_val("ovf", ovf, cur_ovf);
      check_val("neg", neg, cur[7]);
      check_val("zero", is_zero, cur == 8'd0);
      check_val("serial", data_out, (d < WB) ? a_old[d] : 1'b0);
      check_val("commit", commit, (d == WB) && does_commit);
      op_valid = (d == 0) ? v : 1'($urandom);
      op       = (d == 0) ? o : 2'($urandom);
      s_in     = (d < WB) ? s[d] : 1'($urandom);
      @(negedge clk);
    end
  endtask

  // Starts a beat and pulls reset low at digit `at`, checking the immediate reset state.
  task automatic reset_mid(input logic [1:0] o, input logic [7:0] s, input int at);
    for (int d = 0; d < at; d++) begin
      op_valid = (d == 0) ? 1'b1 : 1'($urandom);
      op       = (d == 0) ? o : 2'($urandom);
      s_in     = s[d];
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    a_m   = 8'd0;
    ovf_m = 1'b0;
    check_val("rst_digit", digit, 4'd0);
    check_val("rst_par", par, 8'd0);
    check_val("rst_zero", is_zero, 1'b1);
    check_val("rst_neg", neg, 1'b0);
    check_val("rst_ovf", ovf, 1'b0);
    check_val("rst_commit", commit, 1'b0);
    check_val("rst_serial", data_out, 1'b0);
    check_val("rst_beat_start", beat_start, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check_val("rst_hold_par", par, 8'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rst32_n  = 1'b0;
    s_in     = 1'b0;
    op       = 2'd0;
    op_valid = 1'b0;
    s32      = 1'b0;
    op32     = 2'd0;
    valid32  = 1'b0;
    a_m      = 8'd0;
    ovf_m    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("init_par", par, 8'd0);
    check_val("init_zero", is_zero, 1'b1);
    check_val("init_digit", digit, 4'd0);
    rst_n = 1'b1;

    // Directed sequence
    run_beat(2'd1, 1'b1, 8'h05);   // LDN 5 -> FB
    run_beat(2'd0, 1'b1, 8'hAA);   // NOP: serial out of FB
    run_beat(2'd2, 1'b1, 8'h03);   // SUB 3 -> F8
    run_beat(2'd2, 1'b1, 8'h79);   // SUB 79 -> 7F ovf
    run_beat(2'd3, 1'b0, 8'h12);   // invalid beat: no change
    run_beat(2'd3, 1'b1, 8'h01);   // ADD 1 -> 80 ovf
    run_beat(2'd3, 1'b1, 8'h80);   // ADD 80 -> 00 ovf
    run_beat(2'd1, 1'b1, 8'h80);   // LDN most negative -> 80 ovf
    run_beat(2'd1, 1'b1, 8'h00);   // LDN 0 -> 00
    reset_mid(2'd3, 8'h33, 5);
    run_beat(2'd3, 1'b1, 8'h7F);

    // Random beats
    for (int n = 0; n < 48; n++) begin
      run_beat(2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, 8'($urandom));
    end
    reset_mid(2'd2, 8'($urandom), 3);
    run_beat(2'd2, 1'b1, 8'h01);

    // 32-bit, 1 flyback: LDN 1 then reset mid-beat
    rst32_n = 1'b1;
    for (int d = 0; d < 33; d++) begin
      check_val("d32_digit", digit32, d);
      check_val("d32_commit", commit32, d == 32);
      check_val("d32_par", par32, (d == 32) ? 32'hFFFF_FFFF : 32'h0);
      check_val("d32_ovf", ovf32, 1'b0);
      valid32 = (d == 0) ? 1'b1 : 1'($urandom);
      op32    = (d == 0) ? 2'd1 : 2'($urandom);
      s32     = (d == 0);
      @(negedge clk);
    end
    check_val("d32_neg", neg32, 1'b1);
    check_val("d32_serial", data_out32, 1'b1);
    for (int d = 0; d < 5; d++) begin
      valid32 = 1'b1;
      op32    = (d == 0) ? 2'd3 : 2'($urandom);
      s32     = 1'($urandom);
      @(negedge clk);
    end
    rst32_n = 1'b0;
    #1;
    check_val("d32_rst_par", par32, 32'h0);
    check_val("d32_rst_zero", zero32, 1'b1);
    check_val("d32_rst_commit", commit32, 1'b0);
    check_val("d32_rst_digit", digit32, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
